// File: rtl/interleaver_multirate_if.sv
// ---------------------------------------------------------------------------
// interleaver_multirate_if
// Bit-serial stream bundle between the encoder/puncturer, the multi-rate
// interleaver and the mapper.
//   mode      : constellation of the block starting with this bit
//               (00 BPSK, 01 QPSK, 10 16-QAM, 11 64-QAM)
//   in_valid  : in_data carries a coded bit
//   in_data   : coded bit k, arrival order
//   in_ready  : interleaver can take a bit this cycle
//   out_valid : out_data carries an interleaved bit
//   out_data  : interleaved bit j, ascending order
//   out_first : marks j = 0 of each block
//   out_mode  : mode of the block currently on out_data
// master = stream source/sink around the interleaver, slave = interleaver.
// ---------------------------------------------------------------------------
interface interleaver_multirate_if;
    logic [1:0] mode;
    logic       in_valid;
    logic       in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_data;
    logic       out_first;
    logic [1:0] out_mode;

    modport master (
        output mode, in_valid, in_data,
        input  in_ready, out_valid, out_data, out_first, out_mode
    );

    modport slave (
        input  mode, in_valid, in_data,
        output in_ready, out_valid, out_data, out_first, out_mode
    );
endinterface

// File: rtl/interleaver_multirate.sv
// ---------------------------------------------------------------------------
// interleaver_multirate
// 802.11a block interleaver with per-symbol mode selection (BPSK, QPSK,
// 16-QAM, 64-QAM). Coded bits arrive serially and are written into one of
// two ping-pong banks at their permuted address; a read FSM drains a full
// bank in address order, so the output stream is the interleaved symbol.
//
// Parameters
//   MAX_NCBPS : bits per bank (>= NCBPS of every mode in use)
//   ADDR_W    : bank address width, 2**ADDR_W >= MAX_NCBPS
// Ports
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : stream bundle (slave side), see interleaver_multirate_if
// ---------------------------------------------------------------------------
module interleaver_multirate #(
    parameter int MAX_NCBPS = 288,
    parameter int ADDR_W    = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    interleaver_multirate_if.slave  bus
);

    localparam logic [1:0] MODE_BPSK  = 2'b00;
    localparam logic [1:0] MODE_QPSK  = 2'b01;
    localparam logic [1:0] MODE_QAM16 = 2'b10;
    localparam logic [1:0] MODE_QAM64 = 2'b11;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    // NCBPS - 1 for a mode: index of the last bit of a block
    function automatic logic [ADDR_W-1:0] last_idx_f(input logic [1:0] m);
        logic [ADDR_W-1:0] r;
        case (m)
            MODE_BPSK:  r = ADDR_W'(47);
            MODE_QPSK:  r = ADDR_W'(95);
            MODE_QAM16: r = ADDR_W'(191);
            MODE_QAM64: r = ADDR_W'(287);
            default:    r = ADDR_W'(287);
        endcase
        return r;
    endfunction

    // NCBPS / 16: step of the first permutation index per column
    function automatic logic [ADDR_W-1:0] stride_f(input logic [1:0] m);
        logic [ADDR_W-1:0] r;
        case (m)
            MODE_BPSK:  r = ADDR_W'(3);
            MODE_QPSK:  r = ADDR_W'(6);
            MODE_QAM16: r = ADDR_W'(12);
            MODE_QAM64: r = ADDR_W'(18);
            default:    r = ADDR_W'(18);
        endcase
        return r;
    endfunction

    // Modulo-3 increment for the 64-QAM residue counters
    function automatic logic [1:0] inc_mod3_f(input logic [1:0] v);
        logic [1:0] r;
        if (v == 2'd2) begin
            r = 2'd0;
        end else begin
            r = v + 2'd1;
        end
        return r;
    endfunction

    // Storage and per-bank state
    logic                  bank_r [0:1][0:MAX_NCBPS-1];
    logic [1:0][1:0]       bank_mode_r;
    logic [1:0]            full_r;
    logic                  wr_ptr_r;
    logic                  rd_ptr_r;
    logic                  in_ready_r;

    // Write-side counters: k, column (k mod 16), row (k / 16),
    // base = stride * column, and residues mod 3 of row and column
    logic [ADDR_W-1:0]     k_r;
    logic [3:0]            col_r;
    logic [ADDR_W-1:0]     row_r;
    logic [ADDR_W-1:0]     base_r;
    logic [1:0]            col_m3_r;
    logic [1:0]            row_m3_r;

    // Read side
    logic [0:0]            state_r;
    logic [ADDR_W-1:0]     rd_addr_r;
    logic                  out_valid_r;
    logic                  out_data_r;
    logic                  out_first_r;
    logic [1:0]            out_mode_r;

    logic [1:0]            cur_mode_s;
    logic [ADDR_W-1:0]     i_s;
    logic [2:0]            m3_sum_s;
    logic [2:0]            m3_rot_s;
    logic [ADDR_W-1:0]     wr_addr_s;
    logic                  accept_s;
    logic                  wr_last_s;
    logic                  rd_last_s;
    logic [1:0]            full_nxt_s;
    logic                  wr_ptr_nxt_s;
    logic                  other_full_s;

    // Mode in force for the bit being written: live input on k = 0, latched copy afterwards
    always_comb begin
        cur_mode_s = bank_mode_r[wr_ptr_r];
        if (k_r == {ADDR_W{1'b0}}) begin
            cur_mode_s = bus.mode;
        end else begin
            cur_mode_s = bank_mode_r[wr_ptr_r];
        end
    end

    // Permuted write address j(k). i = stride*col + row. Since
    // floor(16i/NCBPS) equals col, the second permutation only needs
    // i mod s and col mod s. For 16-QAM (s = 2, NCBPS even) that is an
    // LSB swap; for 64-QAM (s = 3) stride 18 is a multiple of 3, so
    // i mod 3 = row mod 3 and the rotation is (row - col) mod 3.
    always_comb begin
        i_s      = base_r + row_r;
        m3_sum_s = {1'b0, row_m3_r} + 3'd3 - {1'b0, col_m3_r};
        if (m3_sum_s >= 3'd3) begin
            m3_rot_s = m3_sum_s - 3'd3;
        end else begin
            m3_rot_s = m3_sum_s;
        end
        case (cur_mode_s)
            MODE_QAM16: wr_addr_s = {i_s[ADDR_W-1:1], i_s[0] ^ col_r[0]};
            MODE_QAM64: wr_addr_s = i_s - ADDR_W'(row_m3_r) + ADDR_W'(m3_rot_s);
            default:    wr_addr_s = i_s;
        endcase
    end

    // Handshake, block-end detection and next full/pointer state
    always_comb begin
        accept_s     = bus.in_valid & in_ready_r;
        wr_last_s    = accept_s & (k_r == last_idx_f(cur_mode_s));
        rd_last_s    = (state_r == ST_DRAIN) &
                       (rd_addr_r == last_idx_f(bank_mode_r[rd_ptr_r]));
        // A bank is never written and drained at once, so set and clear never meet
        full_nxt_s[0] = (full_r[0] | (wr_last_s & ~wr_ptr_r)) & ~(rd_last_s & ~rd_ptr_r);
        full_nxt_s[1] = (full_r[1] | (wr_last_s &  wr_ptr_r)) & ~(rd_last_s &  rd_ptr_r);
        wr_ptr_nxt_s = wr_ptr_r ^ wr_last_s;
        // The other bank counts as ready if it completes on this very edge,
        // which keeps back-to-back blocks gap-free on the output
        other_full_s = full_r[~rd_ptr_r] | (wr_last_s & (wr_ptr_r != rd_ptr_r));
    end

    // Bit storage; no reset needed since the full flags gate every read
    always_ff @(posedge clk) begin
        if (accept_s) begin
            bank_r[wr_ptr_r][wr_addr_s] <= bus.in_data;
        end
    end

    // Write side: counters, mode latch, full flags, write pointer, in_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_mode_r <= {2'b00, 2'b00};
            full_r      <= 2'b00;
            wr_ptr_r    <= 1'b0;
            in_ready_r  <= 1'b0;
            k_r         <= {ADDR_W{1'b0}};
            col_r       <= 4'd0;
            row_r       <= {ADDR_W{1'b0}};
            base_r      <= {ADDR_W{1'b0}};
            col_m3_r    <= 2'd0;
            row_m3_r    <= 2'd0;
        end else begin
            full_r     <= full_nxt_s;
            wr_ptr_r   <= wr_ptr_nxt_s;
            in_ready_r <= ~full_nxt_s[wr_ptr_nxt_s];
            if (accept_s) begin
                if (k_r == {ADDR_W{1'b0}}) begin
                    bank_mode_r[wr_ptr_r] <= bus.mode;
                end
                if (wr_last_s) begin
                    k_r      <= {ADDR_W{1'b0}};
                    col_r    <= 4'd0;
                    row_r    <= {ADDR_W{1'b0}};
                    base_r   <= {ADDR_W{1'b0}};
                    col_m3_r <= 2'd0;
                    row_m3_r <= 2'd0;
                end else begin
                    k_r <= k_r + ADDR_W'(1);
                    if (col_r == 4'd15) begin
                        col_r    <= 4'd0;
                        base_r   <= {ADDR_W{1'b0}};
                        col_m3_r <= 2'd0;
                        row_r    <= row_r + ADDR_W'(1);
                        row_m3_r <= inc_mod3_f(row_m3_r);
                    end else begin
                        col_r    <= col_r + 4'd1;
                        base_r   <= base_r + stride_f(cur_mode_s);
                        col_m3_r <= inc_mod3_f(col_m3_r);
                    end
                end
            end
        end
    end

    // Read FSM: drains a full bank in address order and registers the outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rd_ptr_r    <= 1'b0;
            rd_addr_r   <= {ADDR_W{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= 1'b0;
            out_first_r <= 1'b0;
            out_mode_r  <= 2'b00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (full_r[rd_ptr_r]) begin
                        // rd_addr_r is always 0 here
                        out_valid_r <= 1'b1;
                        out_data_r  <= bank_r[rd_ptr_r][rd_addr_r];
                        out_first_r <= 1'b1;
                        out_mode_r  <= bank_mode_r[rd_ptr_r];
                        rd_addr_r   <= ADDR_W'(1);
                        state_r     <= ST_DRAIN;
                    end else begin
                        out_valid_r <= 1'b0;
                        out_data_r  <= 1'b0;
                        out_first_r <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= bank_r[rd_ptr_r][rd_addr_r];
                    out_first_r <= (rd_addr_r == {ADDR_W{1'b0}});
                    out_mode_r  <= bank_mode_r[rd_ptr_r];
                    if (rd_last_s) begin
                        rd_addr_r <= {ADDR_W{1'b0}};
                        rd_ptr_r  <= ~rd_ptr_r;
                        state_r   <= other_full_s ? ST_DRAIN : ST_IDLE;
                    end else begin
                        rd_addr_r <= rd_addr_r + ADDR_W'(1);
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rd_addr_r   <= {ADDR_W{1'b0}};
                    out_valid_r <= 1'b0;
                    out_data_r  <= 1'b0;
                    out_first_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_first = out_first_r;
    assign bus.out_mode  = out_mode_r;

endmodule

// File: tb/tb_interleaver_multirate.sv
// ---------------------------------------------------------------------------
// tb_interleaver_multirate
// Self-checking bench: a reference permutation (direct 802.11a formulas)
// fills a scoreboard queue as blocks are driven; a negedge monitor pops and
// compares every output bit, and a vector table checks one-hot positions.
// ---------------------------------------------------------------------------
module tb_interleaver_multirate;
    localparam int MAX_NCBPS = 288;
    localparam int ADDR_W    = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    interleaver_multirate_if bus();

    interleaver_multirate #(.MAX_NCBPS(MAX_NCBPS), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       d;
        logic       first;
        logic [1:0] mode;
    } exp_t;

    typedef struct {
        logic [1:0] mode;
        int         k1;
        int         k2;
        int         j1;
        int         j2;
        bit         gaps;
    } vec_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       tx_bits [MAX_NCBPS];
    logic       cap [MAX_NCBPS];
    int         cap_len = 0;
    int         first_cnt = 0;
    int         streak = 0;
    int         max_streak = 0;
    int         ready_low = 0;
    bit         track_ready = 1'b0;
    logic [1:0] mode_log [16];
    int         mode_log_len = 0;
    vec_t       vecs [9];

    function automatic int ncbps_of(input logic [1:0] m);
        case (m)
            2'b00:   return 48;
            2'b01:   return 96;
            2'b10:   return 192;
            default: return 288;
        endcase
    endfunction

    function automatic int nbpsc_of(input logic [1:0] m);
        case (m)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 6;
        endcase
    endfunction

    function automatic int perm_j(input int k, input logic [1:0] m);
        int n, s, i;
        n = ncbps_of(m);
        s = nbpsc_of(m) / 2;
        if (s < 1) s = 1;
        i = (n / 16) * (k % 16) + k / 16;
        return s * (i / s) + (i + n - (16 * i) / n) % s;
    endfunction

    task automatic check_int(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_expected(input logic [1:0] m);
        logic eb [MAX_NCBPS];
        int   n;
        exp_t e;
        n = ncbps_of(m);
        for (int k = 0; k < n; k++) eb[perm_j(k, m)] = tx_bits[k];
        for (int j = 0; j < n; j++) begin
            e.d = eb[j];
            e.first = (j == 0);
            e.mode = m;
            sb_q.push_back(e);
        end
    endtask

    task automatic send_bit(input logic [1:0] m, input logic b);
        int waited;
        waited = 0;
        bus.mode = m;
        bus.in_valid = 1'b1;
        bus.in_data = b;
        while (!bus.in_ready && waited < 2000) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: in_ready=0 after %0d cycles, required 1", waited);
        end
        @(posedge clk); #1;
    endtask

    // Mode is scrambled after k = 0 so a DUT that re-samples it is caught
    task automatic send_block(input logic [1:0] m, input bit gaps, input bit push);
        int n;
        n = ncbps_of(m);
        if (push) push_expected(m);
        for (int k = 0; k < n; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data = 1'($urandom);
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_bit((k == 0) ? m : 2'($urandom), tx_bits[k]);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic fill_random();
        for (int k = 0; k < MAX_NCBPS; k++) tx_bits[k] = 1'($urandom);
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (sb_q.size() != 0 && c < 5000) begin
            @(posedge clk);
            c++;
        end
        repeat (2) @(posedge clk);
        #1;
        check_int("drain_in_time", int'(c < 5000), 1);
    endtask

    task automatic clear_stats();
        first_cnt = 0;
        max_streak = 0;
        ready_low = 0;
        mode_log_len = 0;
    endtask

    // Output monitor: scoreboard compare, block capture, gap and ready tracking
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            streak++;
            if (streak > max_streak) max_streak = streak;
            if (bus.out_first) begin
                cap_len = 0;
                first_cnt++;
                if (mode_log_len < 16) begin
                    mode_log[mode_log_len] = bus.out_mode;
                    mode_log_len++;
                end
            end
            if (cap_len < MAX_NCBPS) begin
                cap[cap_len] = bus.out_data;
                cap_len++;
            end
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: out_valid=1 with no expected bit, required out_valid=0");
            end else begin
                mon_e = sb_q.pop_front();
                if (bus.out_data !== mon_e.d || bus.out_first !== mon_e.first ||
                    bus.out_mode !== mon_e.mode) begin
                    n_fail++;
                    $display("FAIL sb_bit: got data=%0b first=%0b mode=%0b, required data=%0b first=%0b mode=%0b",
                             bus.out_data, bus.out_first, bus.out_mode,
                             mon_e.d, mon_e.first, mon_e.mode);
                end
            end
        end else begin
            streak = 0;
        end
        if (track_ready && rst_n && !bus.in_ready) ready_low++;
    end

    initial begin
        int p1, p2, ones;

        vecs[0] = '{2'b00,   1,  -1,   3,  -1, 1'b0};
        vecs[1] = '{2'b10,  16,  17,   1,  12, 1'b0};
        vecs[2] = '{2'b11,   1,  -1,  20,  -1, 1'b0};
        vecs[3] = '{2'b01,   1,  -1,   6,  -1, 1'b0};
        vecs[4] = '{2'b11,  16,   2,   1,  37, 1'b0};
        vecs[5] = '{2'b00,  47,  -1,  47,  -1, 1'b1};
        vecs[6] = '{2'b01,  47,  -1,  92,  -1, 1'b1};
        vecs[7] = '{2'b10, 191,  -1, 190,  -1, 1'b0};
        vecs[8] = '{2'b11, 287,  -1, 287,  -1, 1'b1};

        bus.mode = 2'b00;
        bus.in_valid = 1'b0;
        bus.in_data = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_int("rst_out_valid", int'(bus.out_valid), 0);
        check_int("rst_out_data",  int'(bus.out_data), 0);
        check_int("rst_out_first", int'(bus.out_first), 0);
        check_int("rst_out_mode",  int'(bus.out_mode), 0);
        check_int("rst_in_ready",  int'(bus.in_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_int("in_ready_after_rst", int'(bus.in_ready), 1);

        // One-hot vector table
        foreach (vecs[v]) begin
            for (int k = 0; k < MAX_NCBPS; k++) tx_bits[k] = 1'b0;
            tx_bits[vecs[v].k1] = 1'b1;
            if (vecs[v].k2 >= 0) tx_bits[vecs[v].k2] = 1'b1;
            clear_stats();
            send_block(vecs[v].mode, vecs[v].gaps, 1'b1);
            wait_drain();
            ones = 0; p1 = -1; p2 = -1;
            for (int j = 0; j < cap_len; j++) begin
                if (cap[j] === 1'b1) begin
                    ones++;
                    if (p1 < 0) p1 = j; else if (p2 < 0) p2 = j;
                end
            end
            check_int($sformatf("vec%0d_ones", v), ones, (vecs[v].k2 >= 0) ? 2 : 1);
            check_int($sformatf("vec%0d_j1", v), p1, vecs[v].j1);
            if (vecs[v].k2 >= 0) check_int($sformatf("vec%0d_j2", v), p2, vecs[v].j2);
            check_int($sformatf("vec%0d_valid_len", v), max_streak, ncbps_of(vecs[v].mode));
            check_int($sformatf("vec%0d_first_cnt", v), first_cnt, 1);
        end

        // Random full-block data, 16-QAM and 64-QAM
        fill_random();
        send_block(2'b10, 1'b0, 1'b1);
        wait_drain();
        fill_random();
        send_block(2'b11, 1'b0, 1'b1);
        wait_drain();

        // Three back-to-back 16-QAM blocks
        clear_stats();
        track_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            fill_random();
            send_block(2'b10, 1'b0, 1'b1);
        end
        wait_drain();
        track_ready = 1'b0;
        check_int("b2b_stream_len", max_streak, 576);
        check_int("b2b_ready_low", ready_low, 0);
        check_int("b2b_first_cnt", first_cnt, 3);

        // Mode switch 64-QAM -> BPSK -> QPSK, continuous input
        clear_stats();
        track_ready = 1'b1;
        fill_random();
        send_block(2'b11, 1'b0, 1'b1);
        fill_random();
        send_block(2'b00, 1'b0, 1'b1);
        fill_random();
        send_block(2'b01, 1'b0, 1'b1);
        wait_drain();
        track_ready = 1'b0;
        check_int("sw_ready_dropped", int'(ready_low > 0), 1);
        check_int("sw_block_cnt", mode_log_len, 3);
        check_int("sw_mode0", int'(mode_log[0]), 3);
        check_int("sw_mode1", int'(mode_log[1]), 0);
        check_int("sw_mode2", int'(mode_log[2]), 1);

        // Reset in the middle of a 16-QAM block, then a fresh BPSK block
        fill_random();
        for (int k = 0; k < 100; k++) send_bit((k == 0) ? 2'b10 : 2'($urandom), tx_bits[k]);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_int("midrst_out_valid", int'(bus.out_valid), 0);
        check_int("midrst_in_ready", int'(bus.in_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_stats();
        fill_random();
        send_block(2'b00, 1'b0, 1'b1);
        wait_drain();
        check_int("postrst_first_cnt", first_cnt, 1);
        check_int("postrst_mode", int'(mode_log[0]), 0);
        check_int("postrst_len", max_streak, 48);

        check_int("sb_empty_at_end", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/interleaver_multirate.md
# interleaver_multirate

Multi-rate 802.11a block interleaver, the parametrised successor to the fixed 16-QAM serial interleaver. It accepts coded bits serially from the convolutional encoder/puncturer and emits them serially, permuted per IEEE 802.11a §17.3.5.6, to the mapper. The NCBPS/NBPSC pair is selected per OFDM symbol: BPSK, QPSK, 16-QAM or 64-QAM. Ping-pong buffering and a valid/ready handshake allow back-to-back symbols, with a mode change allowed between any two of them.

## Interface
- MAX_NCBPS, 288: depth of each bank in bits; must be ≥ the NCBPS of every mode used.
- ADDR_W, 9: bank address width; must satisfy 2^ADDR_W ≥ MAX_NCBPS.

- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Mode  input  2  00 BPSK (NCBPS 48, NBPSC 1), 01 QPSK (96, 2), 10 16-QAM (192, 4), 11 64-QAM (288, 6). Sampled with the first bit of each block.
- InValid  input  1  Input carries a coded bit this cycle.
- Input  input  1  coded bit, index k = 0..NCBPS-1 in arrival order.
- InReady  output  1  block can accept a bit this cycle.
- OutValid  output  1  Output carries an interleaved bit.
- Output  output  1  interleaved bit, index j in order 0..NCBPS-1.
- OutFirst  output  1  high with output bit j = 0 of each block.
- OutMode  output  2  mode of the block currently on Output.

## Operation
- Two banks, A and B, each MAX_NCBPS bits. Each bank has a full flag and a latched mode.
- Bits are written to the write bank. Reads come from the read bank. Both pointers start at A and toggle after each completed block.
- A bit is accepted when InValid && InReady. InReady = !full[write bank].
- On an accepted bit with write counter k = 0, Mode is latched into the write bank. Mode is ignored for the rest of that block.
- Accepted bit k is stored at address j(k):
  - s = max(NBPSC/2, 1).
  - i = (NCBPS/16)·(k mod 16) + floor(k/16).
  - j = s·floor(i/s) + (i + NCBPS − floor(16i/NCBPS)) mod s.
- Implementation rule: floor(16i/NCBPS) = k mod 16. Keep column/row counters and compute i incrementally. No dividers are allowed.
- When k reaches NCBPS−1 and that bit is accepted:
  - Set full on the write bank.
  - Clear k.
  - Toggle the write pointer.
- Read FSM has two states:
  - IDLE → DRAIN when full[read bank] is set.
  - DRAIN outputs addresses 0..NCBPS(read bank)−1, one per cycle, with no gaps and no backpressure.
  - On the last address, clear full[read bank] and toggle the read pointer.
  - If full[other bank] is set, stay in DRAIN so the next block follows with zero gap cycles. Otherwise go to IDLE.
- A write into a bank and the clearing of that bank's full flag in the same cycle cannot collide: InReady is low while the bank is full.
- Gaps in InValid stall only the write side.

## Timing
- Reset values:
  - InReady = 1 from the first cycle after reset deasserts; it is 0 while Reset is low.
  - OutValid = 0, Output = 0, OutFirst = 0, OutMode = 00.
  - Counters = 0, full flags = 0, both pointers = A, FSM = IDLE.
- Latency: if the last bit of a block is accepted at edge E, OutValid, OutFirst and bit j = 0 appear after edge E+1. All outputs are registered.
- OutValid stays high for exactly NCBPS consecutive cycles per block.
- Throughput: continuous 1 bit/cycle input of a constant mode gives continuous output with InReady never low.
- Mode change to a smaller NCBPS: InReady drops while the larger block still drains. There is no data loss and no overwrite.
- Reset asserted mid-block (either side) takes effect immediately and asynchronously:
  - The partial input block and any undrained output are discarded.
  - The first bit accepted after reset is k = 0.
- Mode values are all legal. Behaviour for MAX_NCBPS below the selected NCBPS is undefined (configuration error).

## Test plan
- BPSK, single 1 at k = 1, all other bits 0 → exactly one output 1, at j = 3. OutFirst only on j = 0. OutValid high for 48 cycles.
- 16-QAM, 1s at k = 16 and k = 17 → output 1s at j = 1 and j = 12. Additionally, the 16-QAM Annex G interleaver vector (192 bits) must match bit-exactly.
- 64-QAM, single 1 at k = 1 → output 1 at j = 20. Also run the Annex G 64-QAM vector.
- Back-to-back: three 16-QAM blocks at continuous input → output is continuous for 576 cycles with no gap, and InReady stays 1.
- Mode switch 64-QAM → BPSK → QPSK with continuous InValid:
  - InReady drops during the 64-QAM drain.
  - OutMode tracks 11, 00, 01.
  - No bits are lost.
- Reset pulse at input bit 100 of a 16-QAM block, then a fresh BPSK block → OutValid = 0 during reset, and the first output block is the BPSK block, correctly permuted.
